// File: rtl/sevseg_pkg.sv
// Shared constants for the seven-segment scan controller: segment patterns,
// off-codes and the digit count.
package sevseg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low {g,f,e,d,c,b,a} patterns. Entry i is the glyph for nibble i.
  localparam logic [15:0][6:0] HEX_PAT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // One display image: what a frame shows.
  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  blank;
    logic [3:0]  dp;
    logic [3:0]  blink;
  } disp_t;

  // Power-up image is fully blanked so nothing lights before the first load.
  localparam disp_t DISP_RST = '{value: 16'h0000, blank: 4'hF, dp: 4'h0, blink: 4'h0};

endpackage

// File: rtl/sevseg_scan_ctrl_hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex7seg
  import sevseg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_PAT[nib];

endmodule

// File: rtl/sevseg_scan_ctrl.sv
// Four-digit common-anode scan controller with frame-synchronous double
// buffering, per-digit blanking, decimal points and blinking.
module sevseg_scan_ctrl
  import sevseg_pkg::*;
#(
  parameter int CLKS_PER_DIGIT = 100000,
  parameter int GUARD_CYCLES   = 16,
  parameter int BLINK_FRAMES   = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  blank,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blink_mask,
  input  logic        load,
  output logic        pending,
  output logic        frame_start,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int SW = $clog2(CLKS_PER_DIGIT);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(CLKS_PER_DIGIT - 1);
  localparam logic [SW-1:0] GUARD_V   = SW'(GUARD_CYCLES);
  localparam logic [FW-1:0] FRM_LAST  = FW'(BLINK_FRAMES - 1);

  logic [SW-1:0] slot_cnt;
  logic [1:0]    digit_idx;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  logic          started;   // a boundary has passed since reset

  disp_t shad, act;

  logic       last_slot, boundary, guard, visible;
  logic [3:0] nib;
  logic [6:0] seg_pat;

  assign last_slot = (slot_cnt == SLOT_LAST);
  assign boundary  = last_slot && (digit_idx == 2'd3);
  assign guard     = (slot_cnt < GUARD_V);
  assign visible   = !act.blank[digit_idx] && !(act.blink[digit_idx] && blink_phase);
  assign nib       = act.value[{digit_idx, 2'b00} +: 4];

  hex7seg u_dec (
    .nib (nib),
    .seg (seg_pat)
  );

  // Slot/digit/frame counters and the blink phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt    <= '0;
      digit_idx   <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      started     <= 1'b0;
    end else begin
      slot_cnt <= last_slot ? '0 : slot_cnt + 1'b1;
      if (last_slot) digit_idx <= digit_idx + 2'd1;
      if (boundary) begin
        started <= 1'b1;
        if (frame_cnt == FRM_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // Double buffer: load fills the shadow; a boundary promotes the pre-edge shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      shad    <= DISP_RST;
      act     <= DISP_RST;
      pending <= 1'b0;
    end else begin
      if (boundary && pending) act <= shad;
      if (load) begin
        shad    <= '{value: value, blank: blank, dp: dp_in, blink: blink_mask};
        pending <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end
    end
  end

  // Registered pin drivers, one clock behind the counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= started && (slot_cnt == '0) && (digit_idx == 2'd0);
      if (!guard && visible) begin
        an  <= ~(4'b0001 << digit_idx);
        seg <= seg_pat;
        dp  <= ~act.dp[digit_idx];
      end else begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Randomized self-checking bench for sevseg_scan_ctrl with a frame-level
// reference model (position derived arithmetically from clocks since reset).
module tb_sevseg_scan_ctrl;

  localparam int CPD = 8;
  localparam int GRD = 2;
  localparam int BF  = 2;
  localparam int FRM = 4 * CPD;

  logic        clk = 0;
  logic        rst = 1;
  logic [15:0] value = 0;
  logic [3:0]  blank = 0, dp_in = 0, blink_mask = 0;
  logic        load = 0;
  logic        pending, frame_start, dp;
  logic [3:0]  an;
  logic [6:0]  seg;

  sevseg_scan_ctrl #(.CLKS_PER_DIGIT(CPD), .GUARD_CYCLES(GRD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .value(value), .blank(blank), .dp_in(dp_in),
    .blink_mask(blink_mask), .load(load), .pending(pending),
    .frame_start(frame_start), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, a, e, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          t;                       // clocks since reset release
  logic [15:0] sh_v, ac_v;
  logic [3:0]  sh_b, ac_b, sh_d, ac_d, sh_m, ac_m;
  bit          m_pend;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_fs;
  bit          chk_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      t = 0; m_pend = 0;
      sh_v = 0; ac_v = 0; sh_b = 4'hF; ac_b = 4'hF;
      sh_d = 0; ac_d = 0; sh_m = 0; ac_m = 0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1; e_fs = 0;
    end else begin
      int slot, idx, phase;
      bit vis;
      slot  = t % CPD;
      idx   = (t / CPD) % 4;
      phase = ((t / FRM) / BF) % 2;
      vis   = !ac_b[idx] && !(ac_m[idx] && phase == 1);
      e_fs  = (t > 0) && (t % FRM == 0);
      if (slot < GRD || !vis) begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1;
      end else begin
        e_an  = 4'hF; e_an[idx] = 1'b0;
        e_seg = pat[ac_v[idx*4 +: 4]];
        e_dp  = !ac_d[idx];
      end
      if (t % FRM == FRM - 1 && m_pend) begin
        ac_v = sh_v; ac_b = sh_b; ac_d = sh_d; ac_m = sh_m; m_pend = 0;
      end
      if (load) begin
        sh_v = value; sh_b = blank; sh_d = dp_in; sh_m = blink_mask; m_pend = 1;
      end
      t++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("an", an, e_an);
      chk("seg", seg, e_seg);
      chk("dp", dp, e_dp);
      chk("frame_start", frame_start, e_fs);
      chk("pending", pending, m_pend);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] b, d, m);
    value = v; blank = b; dp_in = d; blink_mask = m; load = 1;
    @(negedge clk);
    load = 0;
  endtask

  // Wait until the next posedge is clock position m within the frame.
  task automatic wait_pos(input int m);
    int n = 0;
    while (t % FRM != m && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("wait_pos_timeout", 1, 0);
  endtask

  task automatic wait_fs();
    int n = 0;
    while (frame_start !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("wait_fs_timeout", 1, 0);
  endtask

  initial begin
    int nb, ndp, nfs;
    rst = 1;
    cyc(3);
    chk_en = 1;
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_pend", pending, 0);
    rst = 0;

    // Reset and first load: 12AF, all visible.
    do_load(16'h12AF, 4'h0, 4'h0, 4'h0);
    chk("dark_before_fs", an, 4'hF);
    wait_fs();
    cyc(2);
    chk("d0_an", an, 4'hE); chk("d0_seg", seg, 7'h0E);
    cyc(8);
    chk("d1_an", an, 4'hD); chk("d1_seg", seg, 7'h08);
    cyc(8);
    chk("d2_an", an, 4'hB); chk("d2_seg", seg, 7'h24);
    cyc(8);
    chk("d3_an", an, 4'h7); chk("d3_seg", seg, 7'h79);

    // No tearing: 0000 then 8888 loaded during digit 2.
    do_load(16'h0000, 4'h0, 4'h0, 4'h0);
    wait_pos(FRM - 1); cyc(1);
    wait_pos(2 * CPD + 3);
    do_load(16'h8888, 4'h0, 4'h0, 4'h0);
    cyc(4);
    chk("tear_seg_old", seg, 7'h40);
    chk("tear_pend", pending, 1);
    wait_fs(); cyc(2);
    chk("tear_seg_new", seg, 7'h00);

    // Load exactly on the boundary edge.
    wait_pos(5);
    do_load(16'h1111, 4'h0, 4'h0, 4'h0);
    wait_pos(FRM - 1);
    do_load(16'h2222, 4'h0, 4'h0, 4'h0);
    chk("bnd_pend", pending, 1);
    cyc(3);
    chk("bnd_seg_old", seg, 7'h79);
    chk("bnd_pend2", pending, 1);
    cyc(32);
    chk("bnd_seg_new", seg, 7'h24);
    chk("bnd_pend3", pending, 0);

    // Blank digit 2, decimal point on digit 0.
    do_load(16'h5678, 4'b0100, 4'b0001, 4'h0);
    cyc(2 * FRM);
    nb = 0; ndp = 0;
    for (int i = 0; i < 2 * FRM; i++) begin
      if (an == 4'hB) nb++;
      if ((dp == 1'b0) != (an == 4'hE)) ndp++;
      @(negedge clk);
    end
    chk("blank_never_B", nb, 0);
    chk("dp_only_d0", ndp, 0);

    // Blink digit 0; model tracks phase over 8 frames.
    do_load(16'h4321, 4'h0, 4'h0, 4'b0001);
    cyc(8 * FRM);

    // Randomized loads.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0)
        do_load(16'($urandom), 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                4'($urandom), 4'($urandom));
      else
        @(negedge clk);
    end

    // Reset mid-operation during digit 2 with a pending load.
    wait_pos(2 * CPD + 1);
    do_load(16'hABCD, 4'h0, 4'h0, 4'h0);
    rst = 1;
    @(negedge clk);
    chk("mrst_an", an, 4'hF);
    chk("mrst_seg", seg, 7'h7F);
    chk("mrst_pend", pending, 0);
    rst = 0;
    nfs = frame_start;
    for (int i = 0; i < 32; i++) begin @(negedge clk); nfs += frame_start; end
    chk("mrst_no_fs", nfs, 0);
    cyc(4 * FRM);
    chk("mrst_dark", an, 4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
